// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS execute stage: ALU operation codes,
// main-control ALUOp codes and the R-type funct values the decoder recognises.
package mips_pkg;

    // Datapath geometry
    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;

    // Decoded ALU operations (alu_control encoding)
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SLL  = 4'b0011;
    localparam logic [3:0] ALU_SRL  = 4'b0100;
    localparam logic [3:0] ALU_SRA  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_XOR  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;
    localparam logic [3:0] ALU_NOR  = 4'b1100;

    // ALUOp codes from main control
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,  // lw / sw address calculation
        ALUOP_SUB   = 2'b01,  // beq compare
        ALUOP_RTYPE = 2'b10,  // decode on funct
        ALUOP_OR    = 2'b11   // ori, zero-extended immediate
    } alu_op_e;

    // R-type funct field values
    localparam logic [5:0] FUNCT_SLL  = 6'b000000;
    localparam logic [5:0] FUNCT_SRL  = 6'b000010;
    localparam logic [5:0] FUNCT_SRA  = 6'b000011;
    localparam logic [5:0] FUNCT_JR   = 6'b001000;
    localparam logic [5:0] FUNCT_ADD  = 6'b100000;
    localparam logic [5:0] FUNCT_ADDU = 6'b100001;
    localparam logic [5:0] FUNCT_SUB  = 6'b100010;
    localparam logic [5:0] FUNCT_SUBU = 6'b100011;
    localparam logic [5:0] FUNCT_AND  = 6'b100100;
    localparam logic [5:0] FUNCT_OR   = 6'b100101;
    localparam logic [5:0] FUNCT_XOR  = 6'b100110;
    localparam logic [5:0] FUNCT_NOR  = 6'b100111;
    localparam logic [5:0] FUNCT_SLT  = 6'b101010;
    localparam logic [5:0] FUNCT_SLTU = 6'b101011;

endpackage

// File: rtl/alu_exec_unit_if.sv
// Execute-stage bus: control/operand inputs driven by the pipeline (master)
// and decode/result outputs produced by the execute unit (slave).
interface alu_exec_unit_if
    import mips_pkg::*;
#(
    parameter int WIDTH    = DATA_W,
    parameter int SHAMT_WD = SHAMT_W
);

    // Inputs to the execute unit
    logic [1:0]          alu_op;
    logic [5:0]          funct;
    logic [SHAMT_WD-1:0] shamt;
    logic [WIDTH-1:0]    a;
    logic [WIDTH-1:0]    b;
    logic [WIDTH-1:0]    add_in0;
    logic [WIDTH-1:0]    add_in1;

    // Outputs from the execute unit
    logic [3:0]          alu_control;
    logic                jr;
    logic                sign_extend;
    logic [WIDTH-1:0]    result_q;
    logic                zero_q;
    logic [WIDTH-1:0]    sum_q;

    modport master (
        output alu_op, funct, shamt, a, b, add_in0, add_in1,
        input  alu_control, jr, sign_extend, result_q, zero_q, sum_q
    );

    modport slave (
        input  alu_op, funct, shamt, a, b, add_in0, add_in1,
        output alu_control, jr, sign_extend, result_q, zero_q, sum_q
    );

endinterface

// File: rtl/alu_exec_unit_adder32.sv
// Generic combinational adder used for the PC+4 / branch-target sum path.
// Carry out is discarded, so the sum wraps modulo 2^WIDTH.
module adder32
    import mips_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] sum_o
);

    assign sum_o = a_i + b_i;

endmodule

// File: rtl/alu_exec_unit.sv
// Execute stage of the single-cycle MIPS core: ALU control decode
// (combinational), 32-bit ALU and address adder with registered results.
module alu_exec_unit
    import mips_pkg::*;
#(
    parameter int WIDTH    = DATA_W,
    parameter int SHAMT_WD = SHAMT_W
) (
    input  logic            clk,
    input  logic            reset,
    alu_exec_unit_if.slave  bus
);

    logic [3:0]       alu_control_d;
    logic             jr_d;
    logic             sign_extend_d;
    logic [WIDTH-1:0] result_d;
    logic             zero_d;
    logic [WIDTH-1:0] sum_d;

    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic [WIDTH-1:0] sum_q;

    // Decode ALUOp/funct into ALU operation, jr and immediate-extension select
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned; a missing default here would infer a latch.
        alu_control_d = ALU_ADD;
        jr_d          = 1'b0;
        sign_extend_d = 1'b1;
        unique case (alu_op_e'(bus.alu_op))
            ALUOP_ADD: alu_control_d = ALU_ADD;
            ALUOP_SUB: alu_control_d = ALU_SUB;
            ALUOP_OR: begin
                alu_control_d = ALU_OR;
                sign_extend_d = 1'b0;
            end
            ALUOP_RTYPE: begin
                case (bus.funct)
                    FUNCT_ADD, FUNCT_ADDU: alu_control_d = ALU_ADD;
                    FUNCT_SUB, FUNCT_SUBU: alu_control_d = ALU_SUB;
                    FUNCT_AND:             alu_control_d = ALU_AND;
                    FUNCT_OR:              alu_control_d = ALU_OR;
                    FUNCT_XOR:             alu_control_d = ALU_XOR;
                    FUNCT_NOR:             alu_control_d = ALU_NOR;
                    FUNCT_SLT:             alu_control_d = ALU_SLT;
                    FUNCT_SLTU:            alu_control_d = ALU_SLTU;
                    FUNCT_SLL:             alu_control_d = ALU_SLL;
                    FUNCT_SRL:             alu_control_d = ALU_SRL;
                    FUNCT_SRA:             alu_control_d = ALU_SRA;
                    FUNCT_JR: begin
                        // jr still drives an ADD so the ALU output stays benign
                        alu_control_d = ALU_ADD;
                        jr_d          = 1'b1;
                    end
                    default:               alu_control_d = ALU_ADD;
                endcase
            end
            default: alu_control_d = ALU_ADD;
        endcase
    end

    assign bus.alu_control = alu_control_d;
    assign bus.jr          = jr_d;
    assign bus.sign_extend = sign_extend_d;

    // ALU datapath; shifts act on operand B by the instruction shamt
    always_comb begin
        result_d = '0;
        case (alu_control_d)
            ALU_AND:  result_d = bus.a & bus.b;
            ALU_OR:   result_d = bus.a | bus.b;
            ALU_XOR:  result_d = bus.a ^ bus.b;
            ALU_NOR:  result_d = ~(bus.a | bus.b);
            ALU_ADD:  result_d = bus.a + bus.b;
            ALU_SUB:  result_d = bus.a - bus.b;
            ALU_SLT:  result_d[0] = ($signed(bus.a) < $signed(bus.b));
            ALU_SLTU: result_d[0] = (bus.a < bus.b);
            ALU_SLL:  result_d = bus.b << bus.shamt;
            ALU_SRL:  result_d = bus.b >> bus.shamt;
            ALU_SRA:  result_d = $unsigned($signed(bus.b) >>> bus.shamt);
            default:  result_d = '0;
        endcase
    end

    // Zero flag derived from the exact value that is registered as the result
    assign zero_d = (result_d == '0);

    adder32 #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a_i   (bus.add_in0),
        .b_i   (bus.add_in1),
        .sum_o (sum_d)
    );

    // Output registers: one-cycle latency, cleared asynchronously by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q <= '0;
            zero_q   <= 1'b0;
            sum_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            result_q <= result_d;
            zero_q   <= zero_d;
            sum_q    <= sum_d;
        end
    end

    assign bus.result_q = result_q;
    assign bus.zero_q   = zero_q;
    assign bus.sum_q    = sum_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit: reset behaviour, decode,
// ALU operations and the wrapping sum path, with hand-computed expectations.
module tb_alu_exec_unit;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    alu_exec_unit_if bus ();

    alu_exec_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a full set of inputs, then settle combinational decode
    task automatic drive(input logic [1:0] op, input logic [5:0] fn, input logic [4:0] sh,
                         input logic [31:0] av, input logic [31:0] bv);
        bus.alu_op = op;
        bus.funct  = fn;
        bus.shamt  = sh;
        bus.a      = av;
        bus.b      = bv;
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        bus.alu_op  = 2'b00;
        bus.funct   = 6'b0;
        bus.shamt   = 5'd0;
        bus.a       = 32'd0;
        bus.b       = 32'd0;
        bus.add_in0 = 32'd0;
        bus.add_in1 = 32'd0;

        // Power-on reset
        repeat (2) @(posedge clk);
        #1;
        check("por_result", bus.result_q, 32'd0);
        check("por_zero",   {31'd0, bus.zero_q}, 32'd0);
        check("por_sum",    bus.sum_q, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Normal operation: lw-style add
        drive(2'b00, 6'b0, 5'd0, 32'd5, 32'd7);
        bus.add_in0 = 32'd1;
        bus.add_in1 = 32'd2;
        check("add_ctrl", {28'd0, bus.alu_control}, 32'h2);
        check("add_sext", {31'd0, bus.sign_extend}, 32'd1);
        tick();
        check("add_result", bus.result_q, 32'd12);
        check("add_zero",   {31'd0, bus.zero_q}, 32'd0);
        check("add_sum",    bus.sum_q, 32'd3);

        // Mid-run asynchronous reset clears immediately, away from an edge
        #2;
        reset = 1'b1;
        #1;
        check("arst_result", bus.result_q, 32'd0);
        check("arst_sum",    bus.sum_q, 32'd0);
        tick();
        check("arst_hold", bus.result_q, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        check("post_rst_result", bus.result_q, 32'd12);
        check("post_rst_sum",    bus.sum_q, 32'd3);

        // sub with equal operands -> zero flag
        @(negedge clk);
        drive(2'b10, 6'b100010, 5'd0, 32'd9, 32'd9);
        check("sub_ctrl", {28'd0, bus.alu_control}, 32'h6);
        tick();
        check("sub_result", bus.result_q, 32'd0);
        check("sub_zero",   {31'd0, bus.zero_q}, 32'd1);

        // subu wraps below zero
        @(negedge clk);
        drive(2'b10, 6'b100011, 5'd0, 32'd0, 32'd1);
        tick();
        check("subu_wrap", bus.result_q, 32'hFFFF_FFFF);
        check("subu_zero", {31'd0, bus.zero_q}, 32'd0);

        // slt vs sltu on -1 and 1
        @(negedge clk);
        drive(2'b10, 6'b101010, 5'd0, 32'hFFFF_FFFF, 32'd1);
        check("slt_ctrl", {28'd0, bus.alu_control}, 32'h7);
        tick();
        check("slt_result", bus.result_q, 32'd1);
        @(negedge clk);
        drive(2'b10, 6'b101011, 5'd0, 32'hFFFF_FFFF, 32'd1);
        check("sltu_ctrl", {28'd0, bus.alu_control}, 32'h9);
        tick();
        check("sltu_result", bus.result_q, 32'd0);
        check("sltu_zero",   {31'd0, bus.zero_q}, 32'd1);

        // Shifts on operand B
        @(negedge clk);
        drive(2'b10, 6'b000011, 5'd4, 32'd0, 32'h8000_0000);
        check("sra_ctrl", {28'd0, bus.alu_control}, 32'h5);
        tick();
        check("sra_result", bus.result_q, 32'hF800_0000);
        @(negedge clk);
        drive(2'b10, 6'b000010, 5'd4, 32'd0, 32'h8000_0000);
        tick();
        check("srl_result", bus.result_q, 32'h0800_0000);
        @(negedge clk);
        drive(2'b10, 6'b000000, 5'd31, 32'd0, 32'h0000_0003);
        check("sll_ctrl", {28'd0, bus.alu_control}, 32'h3);
        tick();
        check("sll_result", bus.result_q, 32'h8000_0000);

        // Bitwise group
        @(negedge clk);
        drive(2'b10, 6'b100100, 5'd0, 32'hF0F0_FF00, 32'h0FF0_F0F0);
        tick();
        check("and_result", bus.result_q, 32'h00F0_F000);
        @(negedge clk);
        drive(2'b10, 6'b100110, 5'd0, 32'hF0F0_FF00, 32'h0FF0_F0F0);
        tick();
        check("xor_result", bus.result_q, 32'hFF00_0FF0);
        @(negedge clk);
        drive(2'b10, 6'b100111, 5'd0, 32'hF0F0_FF00, 32'h0FF0_F0F0);
        check("nor_ctrl", {28'd0, bus.alu_control}, 32'hC);
        tick();
        check("nor_result", bus.result_q, 32'h000F_000F);

        // jr decode and non-R-type suppression of jr
        @(negedge clk);
        drive(2'b10, 6'b001000, 5'd0, 32'd3, 32'd4);
        check("jr_flag", {31'd0, bus.jr}, 32'd1);
        check("jr_ctrl", {28'd0, bus.alu_control}, 32'h2);
        drive(2'b01, 6'b001000, 5'd0, 32'd3, 32'd4);
        check("beq_jr",   {31'd0, bus.jr}, 32'd0);
        check("beq_ctrl", {28'd0, bus.alu_control}, 32'h6);
        drive(2'b10, 6'b111111, 5'd0, 32'd3, 32'd4);
        check("unk_ctrl", {28'd0, bus.alu_control}, 32'h2);
        check("unk_jr",   {31'd0, bus.jr}, 32'd0);

        // ori: OR with zero-extension select
        drive(2'b11, 6'b001000, 5'd0, 32'h0000_00F0, 32'h0000_000F);
        check("ori_ctrl", {28'd0, bus.alu_control}, 32'h1);
        check("ori_sext", {31'd0, bus.sign_extend}, 32'd0);
        check("ori_jr",   {31'd0, bus.jr}, 32'd0);
        tick();
        check("ori_result", bus.result_q, 32'h0000_00FF);

        // Adder path: wrap and PC+4
        @(negedge clk);
        bus.add_in0 = 32'hFFFF_FFFC;
        bus.add_in1 = 32'd4;
        tick();
        check("sum_wrap", bus.sum_q, 32'd0);
        @(negedge clk);
        bus.add_in0 = 32'h0040_0000;
        bus.add_in1 = 32'd4;
        tick();
        check("sum_pc4", bus.sum_q, 32'h0040_0004);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
